// File: rtl/reg_bank_nz.sv
// rtl/reg_bank_nz.sv - Neander register bank with write/increment ports, N/Z flags and wrap pulse
module reg_bank_nz #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REGS   = 4,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  inc_en,
    input  logic [ADDR_WIDTH-1:0] inc_addr,
    input  logic [ADDR_WIDTH-1:0] rd_addr_a,
    output logic [DATA_WIDTH-1:0] rd_data_a,
    input  logic [ADDR_WIDTH-1:0] rd_addr_b,
    output logic [DATA_WIDTH-1:0] rd_data_b,
    output logic                  flag_n,
    output logic                  flag_z,
    output logic                  wrap
);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic                  wr_ok;
    logic                  inc_ok;
    logic [DATA_WIDTH-1:0] inc_cur;

    // A write to the same register as an increment wins, so the increment is dropped here.
    always_comb begin
        wr_ok     = wr_en && (int'(wr_addr) < NUM_REGS);
        inc_ok    = inc_en && (int'(inc_addr) < NUM_REGS) && !(wr_ok && (wr_addr == inc_addr));
        inc_cur   = '0;
        rd_data_a = '0;
        rd_data_b = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (int'(inc_addr) == i)  inc_cur   = regs[i];
            if (int'(rd_addr_a) == i) rd_data_a = regs[i];
            if (int'(rd_addr_b) == i) rd_data_b = regs[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            flag_n <= 1'b0;
            flag_z <= 1'b1;
            wrap   <= 1'b0;
        end else if (clr) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            flag_n <= 1'b0;
            flag_z <= 1'b1;
            wrap   <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_ok && (int'(wr_addr) == i))
                    regs[i] <= wr_data;
                else if (inc_ok && (int'(inc_addr) == i))
                    regs[i] <= regs[i] + 1'b1;
            end
            if (wr_ok) begin
                flag_n <= wr_data[DATA_WIDTH-1];
                flag_z <= (wr_data == '0);
            end
            wrap <= inc_ok && (inc_cur == '1);
        end
    end

endmodule

// File: tb/tb_reg_bank_nz.sv
// tb/tb_reg_bank_nz.sv - self-checking bench for reg_bank_nz in three parameterisations
module tb_reg_bank_nz;

    logic        clk = 1'b0;
    logic        reset, clr, wr_en, inc_en;
    logic [1:0]  wr_addr, inc_addr, rd_addr_a, rd_addr_b;
    logic [15:0] wr_data;

    logic [7:0]  a0, b0, a1, b1;
    logic [15:0] a2, b2;
    logic        n0, z0, w0, n1, z1, w1, n2, z2, w2;

    always #5 clk = ~clk;

    reg_bank_nz #(.DATA_WIDTH(8), .NUM_REGS(4), .ADDR_WIDTH(2)) u8 (
        .clk(clk), .reset(reset), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data[7:0]), .inc_en(inc_en), .inc_addr(inc_addr),
        .rd_addr_a(rd_addr_a), .rd_data_a(a0), .rd_addr_b(rd_addr_b), .rd_data_b(b0),
        .flag_n(n0), .flag_z(z0), .wrap(w0));

    reg_bank_nz #(.DATA_WIDTH(8), .NUM_REGS(3), .ADDR_WIDTH(2)) u3 (
        .clk(clk), .reset(reset), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data[7:0]), .inc_en(inc_en), .inc_addr(inc_addr),
        .rd_addr_a(rd_addr_a), .rd_data_a(a1), .rd_addr_b(rd_addr_b), .rd_data_b(b1),
        .flag_n(n1), .flag_z(z1), .wrap(w1));

    reg_bank_nz #(.DATA_WIDTH(16), .NUM_REGS(4), .ADDR_WIDTH(2)) u16 (
        .clk(clk), .reset(reset), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .inc_en(inc_en), .inc_addr(inc_addr),
        .rd_addr_a(rd_addr_a), .rd_data_a(a2), .rd_addr_b(rd_addr_b), .rd_data_b(b2),
        .flag_n(n2), .flag_z(z2), .wrap(w2));

    logic [15:0] oa [3];
    logic [15:0] ob [3];
    logic        on [3];
    logic        oz [3];
    logic        ow [3];
    assign oa[0] = {8'h00, a0}; assign ob[0] = {8'h00, b0};
    assign oa[1] = {8'h00, a1}; assign ob[1] = {8'h00, b1};
    assign oa[2] = a2;          assign ob[2] = b2;
    assign on[0] = n0; assign on[1] = n1; assign on[2] = n2;
    assign oz[0] = z0; assign oz[1] = z1; assign oz[2] = z2;
    assign ow[0] = w0; assign ow[1] = w1; assign ow[2] = w2;

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model: each bank is an array of integers updated by the rules, modulo 2**width.
    int unsigned mr [3][4];
    bit          mn [3];
    bit          mz [3];
    bit          mw [3];
    int unsigned width [3] = '{8, 8, 16};
    int unsigned nregs [3] = '{4, 3, 4};

    function automatic int unsigned mread(int k, int unsigned addr);
        return (addr < nregs[k]) ? mr[k][addr] : 0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 4; i++) mr[k][i] = 0;
            mn[k] = 0; mz[k] = 1; mw[k] = 0;
        end
    endtask

    task automatic cycle();
        int unsigned nr [3][4];
        bit nn [3], nz [3], nw [3];
        for (int k = 0; k < 3; k++) begin
            int unsigned lim = 32'd1 << width[k];
            bit wa, ia;
            for (int i = 0; i < 4; i++) nr[k][i] = mr[k][i];
            nn[k] = mn[k]; nz[k] = mz[k]; nw[k] = mw[k];
            if (reset) continue;
            if (clr) begin
                for (int i = 0; i < 4; i++) nr[k][i] = 0;
                nn[k] = 0; nz[k] = 1; nw[k] = 0;
                continue;
            end
            wa = wr_en && (wr_addr < nregs[k]);
            ia = inc_en && (inc_addr < nregs[k]) && !(wa && wr_addr == inc_addr);
            nw[k] = ia && (mr[k][inc_addr] == lim - 1);
            if (ia) nr[k][inc_addr] = (mr[k][inc_addr] + 1) % lim;
            if (wa) begin
                int unsigned d = wr_data % lim;
                nr[k][wr_addr] = d;
                nn[k] = (d >= lim / 2);
                nz[k] = (d == 0);
            end
        end
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 4; i++) mr[k][i] = nr[k][i];
            mn[k] = nn[k]; mz[k] = nz[k]; mw[k] = nw[k];
        end
        #1;
    endtask

    task automatic idle();
        clr = 0; wr_en = 0; inc_en = 0; wr_addr = 0; inc_addr = 0; wr_data = 0;
    endtask

    task automatic do_write(input logic [1:0] addr, input logic [15:0] data);
        idle(); wr_en = 1; wr_addr = addr; wr_data = data;
        cycle();
        idle();
    endtask

    task automatic test_reset();
        reset = 1; idle(); rd_addr_a = 0; rd_addr_b = 0; model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int a = 0; a < 4; a++) begin
            rd_addr_a = 2'(a); rd_addr_b = 2'(3 - a); #1;
            n_vec++; if (a0 !== 8'h00) begin n_fail++; $display("FAIL reset_rd_a addr=%0d got=%h exp=00", a, a0); end
            n_vec++; if (b0 !== 8'h00) begin n_fail++; $display("FAIL reset_rd_b addr=%0d got=%h exp=00", 3 - a, b0); end
        end
        n_vec++; if ({n0, z0, w0} !== 3'b010) begin n_fail++; $display("FAIL reset_flags got nzw=%b exp=010", {n0, z0, w0}); end
        reset = 0;
        for (int i = 0; i < 4; i++) begin
            wr_en = 1; wr_addr = 2'(i); wr_data = {8'h01, 8'h40 | 8'($urandom)};
            cycle();
        end
        rd_addr_a = 3; #1;
        n_vec++; if (a0 === 8'h00) begin n_fail++; $display("FAIL burst_written got=%h exp=nonzero", a0); end
        #1 reset = 1; model_reset(); #1;
        n_vec++; if (a0 !== 8'h00) begin n_fail++; $display("FAIL async_reset_rd got=%h exp=00", a0); end
        n_vec++; if ({n0, z0, w0} !== 3'b010) begin n_fail++; $display("FAIL async_reset_flags got nzw=%b exp=010", {n0, z0, w0}); end
        idle();
        cycle(); cycle();
        reset = 0;
    endtask

    task automatic test_write();
        logic [1:0] addrs [3] = '{2'd1, 2'd2, 2'd3};
        logic [7:0] datas [3] = '{8'h80, 8'h00, 8'h3C};
        logic [1:0] nz    [3] = '{2'b10, 2'b01, 2'b00};
        for (int i = 0; i < 3; i++) begin
            wr_en = 1; wr_addr = addrs[i]; wr_data = {8'h00, datas[i]}; rd_addr_a = addrs[i]; #1;
            n_vec++; if (a0 !== 8'h00) begin n_fail++; $display("FAIL write_old_value addr=%0d got=%h exp=00", addrs[i], a0); end
            cycle();
            n_vec++; if (a0 !== datas[i]) begin n_fail++; $display("FAIL write_read addr=%0d got=%h exp=%h", addrs[i], a0, datas[i]); end
            n_vec++; if ({n0, z0} !== nz[i]) begin n_fail++; $display("FAIL write_flags addr=%0d got nz=%b exp=%b", addrs[i], {n0, z0}, nz[i]); end
        end
        idle();
    endtask

    task automatic test_increment();
        logic [7:0] vals  [3] = '{8'hFF, 8'h00, 8'h01};
        logic       wraps [3] = '{1'b0, 1'b1, 1'b0};
        do_write(0, 16'h00FE);
        inc_en = 1; inc_addr = 0; rd_addr_a = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_vec++; if (a0 !== vals[i]) begin n_fail++; $display("FAIL inc_value step=%0d got=%h exp=%h", i, a0, vals[i]); end
            n_vec++; if (w0 !== wraps[i]) begin n_fail++; $display("FAIL inc_wrap step=%0d got=%b exp=%b", i, w0, wraps[i]); end
        end
        idle(); cycle();
        n_vec++; if ({n0, z0, w0} !== 3'b100) begin n_fail++; $display("FAIL inc_flags got nzw=%b exp=100", {n0, z0, w0}); end
    endtask

    task automatic test_collision();
        do_write(2, 16'h00FF);
        wr_en = 1; wr_addr = 2; wr_data = 16'h0055; inc_en = 1; inc_addr = 2;
        cycle(); idle();
        rd_addr_a = 2; #1;
        n_vec++; if (a0 !== 8'h55) begin n_fail++; $display("FAIL same_addr_write_wins got=%h exp=55", a0); end
        n_vec++; if (w0 !== 1'b0) begin n_fail++; $display("FAIL same_addr_wrap got=%b exp=0", w0); end
        wr_en = 1; wr_addr = 1; wr_data = 16'h0010; inc_en = 1; inc_addr = 0;
        cycle(); idle();
        rd_addr_a = 1; rd_addr_b = 0; #1;
        n_vec++; if (a0 !== 8'h10) begin n_fail++; $display("FAIL dual_write got=%h exp=10", a0); end
        n_vec++; if (b0 !== 8'h02) begin n_fail++; $display("FAIL dual_inc got=%h exp=02", b0); end
    endtask

    task automatic test_out_of_range();
        do_write(3, 16'h00AA);
        rd_addr_a = 3; #1;
        n_vec++; if ({n1, z1} !== 2'b00) begin n_fail++; $display("FAIL oor_flags got nz=%b exp=00", {n1, z1}); end
        n_vec++; if (a1 !== 8'h00) begin n_fail++; $display("FAIL oor_read got=%h exp=00", a1); end
        inc_en = 1; inc_addr = 3; cycle(); idle();
        rd_addr_b = 2; #1;
        n_vec++; if (w1 !== 1'b0) begin n_fail++; $display("FAIL oor_inc_wrap got=%b exp=0", w1); end
        n_vec++; if (b1 !== 8'h55) begin n_fail++; $display("FAIL oor_r2_kept got=%h exp=55", b1); end
        n_vec++; if (a1 !== 8'h00) begin n_fail++; $display("FAIL oor_inc_read got=%h exp=00", a1); end
    endtask

    task automatic test_clear();
        do_write(0, 16'h00FF);
        clr = 1; wr_en = 1; wr_addr = 1; wr_data = 16'h0077; inc_en = 1; inc_addr = 0;
        cycle(); idle();
        for (int a = 0; a < 4; a++) begin
            rd_addr_a = 2'(a); #1;
            n_vec++; if (a0 !== 8'h00) begin n_fail++; $display("FAIL clr_rd addr=%0d got=%h exp=00", a, a0); end
        end
        n_vec++; if ({n0, z0, w0} !== 3'b010) begin n_fail++; $display("FAIL clr_flags got nzw=%b exp=010", {n0, z0, w0}); end
    endtask

    task automatic test_wide();
        do_write(0, 16'hFFFE);
        rd_addr_a = 0; inc_en = 1; inc_addr = 0;
        cycle();
        n_vec++; if ({a2, w2} !== {16'hFFFF, 1'b0}) begin n_fail++; $display("FAIL wide_inc1 got=%h/%b exp=ffff/0", a2, w2); end
        cycle(); idle();
        n_vec++; if ({a2, w2} !== {16'h0000, 1'b1}) begin n_fail++; $display("FAIL wide_wrap got=%h/%b exp=0000/1", a2, w2); end
        cycle();
        n_vec++; if (w2 !== 1'b0) begin n_fail++; $display("FAIL wide_wrap_clear got=%b exp=0", w2); end
        n_vec++; if ({n2, z2} !== 2'b10) begin n_fail++; $display("FAIL wide_flags got nz=%b exp=10", {n2, z2}); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] pick [5] = '{16'h0000, 16'hFFFF, 16'h00FF, 16'h0080, 16'h1234};
        reset = 1; idle(); model_reset(); cycle(); reset = 0;
        for (int t = 0; t < 400; t++) begin
            clr      = ($urandom_range(0, 31) == 0);
            wr_en    = ($urandom_range(0, 2) == 0);
            wr_addr  = 2'($urandom);
            wr_data  = ($urandom_range(0, 1) == 0) ? pick[$urandom_range(0, 4)] : 16'($urandom);
            inc_en   = ($urandom_range(0, 1) == 0);
            inc_addr = 2'($urandom);
            rd_addr_a = 2'($urandom);
            rd_addr_b = 2'($urandom);
            cycle();
            for (int k = 0; k < 3; k++) begin
                n_vec++; if (oa[k] !== 16'(mread(k, rd_addr_a))) begin n_fail++; $display("FAIL rand_rd_a t=%0d k=%0d got=%h exp=%h", t, k, oa[k], 16'(mread(k, rd_addr_a))); end
                n_vec++; if (ob[k] !== 16'(mread(k, rd_addr_b))) begin n_fail++; $display("FAIL rand_rd_b t=%0d k=%0d got=%h exp=%h", t, k, ob[k], 16'(mread(k, rd_addr_b))); end
                n_vec++; if ({on[k], oz[k], ow[k]} !== {mn[k], mz[k], mw[k]}) begin n_fail++; $display("FAIL rand_flags t=%0d k=%0d got nzw=%b exp=%b", t, k, {on[k], oz[k], ow[k]}, {mn[k], mz[k], mw[k]}); end
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_write();
        test_increment();
        test_collision();
        test_out_of_range();
        test_clear();
        test_wide();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
